// File: rtl/handshake_xbar_arbiter_pkg.sv
// Shared definitions for the 2x2 handshake crossbar arbiter.
// Contents:
//   arb_state_e          per-slave arbiter state; the encoding doubles as the
//                        one-hot owner value driven on gnt_s0/gnt_s1
//   DEF_S0/S1_TAG        default destination tags
//   TAG_HI/TAG_LO        position of the destination tag inside a beat
package handshake_xbar_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    OWN_M0 = 2'b01,
    OWN_M1 = 2'b10
  } arb_state_e;

  localparam logic [3:0] DEF_S0_TAG = 4'h2;
  localparam logic [3:0] DEF_S1_TAG = 4'h3;

  localparam int TAG_HI = 7;
  localparam int TAG_LO = 4;

endpackage

// File: rtl/handshake_xbar_arbiter_rr_arb2.sv
// rr_arb2: single-beat arbiter for one slave, shared by two masters.
// Ports:
//   clk, rst   clock / synchronous active-low reset
//   req_i[m]   master m has a valid beat decoded to this slave
//   hs_i       valid && ready on this slave's output side
//   gnt_o      registered state: 00 idle, 01 M0 owns, 10 M1 owns
// A grant covers exactly one beat; the handshake returns the FSM to IDLE
// and hands preference to the master that was just served's peer.
module rr_arb2
  import handshake_xbar_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       hs_i,
  output logic [1:0] gnt_o
);

  arb_state_e state_q, state_d;
  logic       rr_q, rr_d;   // 0: M0 preferred on a tie

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (req_i == 2'b11)  state_d = rr_q ? OWN_M1 : OWN_M0;
        else if (req_i[0])   state_d = OWN_M0;
        else if (req_i[1])   state_d = OWN_M1;
      end
      OWN_M0: if (hs_i) begin
        state_d = IDLE;
        rr_d    = 1'b1;
      end
      OWN_M1: if (hs_i) begin
        state_d = IDLE;
        rr_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_o = state_q;

endmodule

// File: rtl/handshake_xbar_arbiter.sv
// handshake_xbar_arbiter: 2-master x 2-slave valid/ready crossbar.
// Ports:
//   clk, rst                 clock / synchronous active-low reset
//   data_m*, valid_m*        master beats; data[7:4] selects the slave
//   ready_m*                 master ready (slave path OR decode-error sink)
//   data_s*, valid_s*        slave beats, muxed from the current owner
//   ready_s*                 slave ready
//   gnt_s*                   registered one-hot owner of each slave
//   decerr_m*                one-cycle pulse when an undecodable beat is dropped
// Each slave has its own rr_arb2; decode, the error sink and the muxes live here.
module handshake_xbar_arbiter
  import handshake_xbar_arbiter_pkg::*;
#(
  parameter int         DW     = 8,
  parameter logic [3:0] S0_TAG = DEF_S0_TAG,
  parameter logic [3:0] S1_TAG = DEF_S1_TAG
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_m0,
  input  logic [DW-1:0] data_m1,
  input  logic          valid_m0,
  input  logic          valid_m1,
  output logic          ready_m0,
  output logic          ready_m1,
  output logic [DW-1:0] data_s0,
  output logic [DW-1:0] data_s1,
  output logic          valid_s0,
  output logic          valid_s1,
  input  logic          ready_s0,
  input  logic          ready_s1,
  output logic [1:0]    gnt_s0,
  output logic [1:0]    gnt_s1,
  output logic          decerr_m0,
  output logic          decerr_m1
);

  localparam int NM = 2;
  localparam int NS = 2;

  logic [NM-1:0][DW-1:0] data_m;
  logic [NM-1:0]         valid_m, bad_m, ready_m;
  logic [NS-1:0][NM-1:0] req, gnt, own;   // [slave][master]
  logic [NS-1:0][DW-1:0] data_s, data_q;
  logic [NS-1:0]         valid_s, ready_s, hs;
  logic [NS-1:0][3:0]    slv_tag;
  logic [NM-1:0]         decerr_q, decerr_d;

  assign data_m  = {data_m1, data_m0};
  assign valid_m = {valid_m1, valid_m0};
  assign ready_s = {ready_s1, ready_s0};
  assign slv_tag = {S1_TAG, S0_TAG};

  // A beat requests exactly one slave by its tag; anything else is an error.
  always_comb begin
    req   = '0;
    bad_m = '0;
    for (int m = 0; m < NM; m++) begin
      for (int s = 0; s < NS; s++)
        req[s][m] = valid_m[m] && (data_m[m][TAG_HI:TAG_LO] == slv_tag[s]);
      bad_m[m] = valid_m[m] && !(req[0][m] || req[1][m]);
    end
  end

  for (genvar s = 0; s < NS; s++) begin : g_slv
    rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i (req[s]),
      .hs_i  (hs[s]),
      .gnt_o (gnt[s])
    );
    // Masking with rst keeps a grant from completing a handshake in the
    // cycle that reset is being applied, so an aborted beat is never taken.
    assign own[s]     = gnt[s] & {NM{rst}};
    assign valid_s[s] = |(own[s] & valid_m);
    assign data_s[s]  = own[s][0] ? data_m[0] :
                        own[s][1] ? data_m[1] : data_q[s];
    assign hs[s]      = valid_s[s] & ready_s[s];
  end

  // Idle slaves keep showing the last beat they carried.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NS; s++) begin
      if (!rst)            data_q[s] <= '0;
      else if (|own[s])    data_q[s] <= data_s[s];
    end
  end

  // Error sink: accept one bad beat the cycle after it is seen. The cycle
  // following the pulse still shows the consumed beat, so it cannot re-fire.
  assign decerr_d = bad_m & ~decerr_q;

  always_ff @(posedge clk) begin
    if (!rst) decerr_q <= '0;
    else      decerr_q <= decerr_d;
  end

  always_comb begin
    ready_m = '0;
    for (int m = 0; m < NM; m++) begin
      for (int s = 0; s < NS; s++)
        ready_m[m] = ready_m[m] | (own[s][m] & ready_s[s]);
      ready_m[m] = ready_m[m] | (decerr_q[m] & rst);
    end
  end

  assign ready_m0  = ready_m[0];
  assign ready_m1  = ready_m[1];
  assign data_s0   = data_s[0];
  assign data_s1   = data_s[1];
  assign valid_s0  = valid_s[0];
  assign valid_s1  = valid_s[1];
  assign gnt_s0    = gnt[0];
  assign gnt_s1    = gnt[1];
  assign decerr_m0 = decerr_q[0] & rst;
  assign decerr_m1 = decerr_q[1] & rst;

endmodule

// File: tb/tb_handshake_xbar_arbiter.sv
// Bench for handshake_xbar_arbiter: directed scenarios with cycle checks plus
// randomized traffic. Drivers push the expected fate of each beat (slave and
// data, or decode error) per master; a monitor pops on every master handshake.
module tb_handshake_xbar_arbiter;
  localparam int         DW = 8;
  localparam logic [3:0] T0 = 4'h2;
  localparam logic [3:0] T1 = 4'h3;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_m0, data_m1, data_s0, data_s1;
  logic          valid_m0, valid_m1, ready_m0, ready_m1;
  logic          valid_s0, valid_s1, ready_s0, ready_s1;
  logic [1:0]    gnt_s0, gnt_s1;
  logic          decerr_m0, decerr_m1;

  int n_cmp = 0, n_err = 0;
  int s_hs = 0, m_hs = 0;
  bit rand_rdy = 1'b0;

  always #5 clk = ~clk;

  handshake_xbar_arbiter #(.DW(DW), .S0_TAG(T0), .S1_TAG(T1)) dut (
    .clk(clk), .rst(rst),
    .data_m0(data_m0), .data_m1(data_m1),
    .valid_m0(valid_m0), .valid_m1(valid_m1),
    .ready_m0(ready_m0), .ready_m1(ready_m1),
    .data_s0(data_s0), .data_s1(data_s1),
    .valid_s0(valid_s0), .valid_s1(valid_s1),
    .ready_s0(ready_s0), .ready_s1(ready_s1),
    .gnt_s0(gnt_s0), .gnt_s1(gnt_s1),
    .decerr_m0(decerr_m0), .decerr_m1(decerr_m1)
  );

  logic [1:0]       vm_w, rm_w, de_w, vs_w, rs_w;
  logic [1:0][7:0]  dm_w, ds_w;
  logic [1:0][1:0]  gs_w;
  assign vm_w = {valid_m1, valid_m0};
  assign rm_w = {ready_m1, ready_m0};
  assign de_w = {decerr_m1, decerr_m0};
  assign vs_w = {valid_s1, valid_s0};
  assign rs_w = {ready_s1, ready_s0};
  assign dm_w = {data_m1, data_m0};
  assign ds_w = {data_s1, data_s0};
  assign gs_w = {gnt_s1, gnt_s0};

  // dest: 0 = slave 0, 1 = slave 1, 2 = decode error
  typedef struct { int dest; logic [7:0] data; } exp_t;
  exp_t q0[$], q1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mk(input int dest);
    logic [3:0] t;
    if (dest == 0)      t = T0;
    else if (dest == 1) t = T1;
    else begin
      do t = 4'($urandom_range(0, 15)); while (t == T0 || t == T1);
    end
    return {t, 4'($urandom)};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the handshake cycle.
  task automatic send(input int m, input int dest, input logic [7:0] d);
    exp_t e;
    bit done;
    done   = 1'b0;
    e.dest = dest;
    e.data = d;
    if (m == 0) begin q0.push_back(e); data_m0 = d; valid_m0 = 1'b1; end
    else        begin q1.push_back(e); data_m1 = d; valid_m1 = 1'b1; end
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      done = (m == 0) ? (valid_m0 && ready_m0) : (valid_m1 && ready_m1);
      tick();
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout m%0d: no handshake, expected one within 300 cycles", m);
    end
    if (m == 0) valid_m0 = 1'b0; else valid_m1 = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("reset_quiet", {28'd0, valid_s1, valid_s0, ready_m1, ready_m0}, 32'd0);
    end else begin
      if (valid_s0 && ready_s0) s_hs++;
      if (valid_s1 && ready_s1) s_hs++;
      for (int m = 0; m < 2; m++) begin
        if (de_w[m]) chk($sformatf("decerr_rdy_m%0d", m), rm_w[m], 1);
        if (vm_w[m] && rm_w[m]) begin
          if ((m == 0 ? q0.size() : q1.size()) == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_hs m%0d: beat %0h accepted, expected none", m, dm_w[m]);
          end else begin
            if (m == 0) e = q0.pop_front(); else e = q1.pop_front();
            if (e.dest == 2) begin
              chk($sformatf("decerr_m%0d", m), de_w[m], 1);
              chk($sformatf("err_nofwd_m%0d", m),
                  {vs_w[1] & gs_w[1][m], vs_w[0] & gs_w[0][m]}, 0);
            end else begin
              m_hs++;
              chk($sformatf("route_gnt_m%0d", m), gs_w[e.dest], (m == 0) ? 2'b01 : 2'b10);
              chk($sformatf("route_hs_m%0d", m), vs_w[e.dest] & rs_w[e.dest], 1);
              chk($sformatf("route_data_m%0d", m), ds_w[e.dest], e.data);
              chk($sformatf("no_decerr_m%0d", m), de_w[m], 0);
            end
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      ready_s0 = ($urandom_range(0, 3) != 0);
      ready_s1 = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic contention(input logic [1:0] first, input logic [1:0] second);
    ready_s0 = 1'b1;
    fork
      send(0, 0, 8'h21);
      send(1, 0, 8'h2A);
      begin
        @(negedge clk); chk("cont_c0", gnt_s0, 2'b00);
        @(negedge clk); chk("cont_first", gnt_s0, first);
        @(negedge clk); chk("cont_gap", gnt_s0, 2'b00);
        @(negedge clk); chk("cont_second", gnt_s0, second);
      end
    join
    tick();
  endtask

  task automatic master_run(input int m, input int n);
    int d;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      d = $urandom_range(0, 4);
      d = (d < 2) ? 0 : (d < 4) ? 1 : 2;
      send(m, d, mk(d));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    data_m0 = 8'h25; data_m1 = 8'h35;
    valid_m0 = 1'b1; valid_m1 = 1'b1;
    ready_s0 = 1'b1; ready_s1 = 1'b1;

    // Reset with all valids high
    repeat (3) tick();
    @(negedge clk);
    chk("rst_gnt", {gnt_s1, gnt_s0}, 4'h0);
    chk("rst_vld", {valid_s1, valid_s0}, 0);
    chk("rst_rdy", {ready_m1, ready_m0}, 0);
    chk("rst_decerr", {decerr_m1, decerr_m0}, 0);
    chk("rst_data", {data_s1, data_s0}, 16'h0000);
    valid_m0 = 1'b0; valid_m1 = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Contention: rr starts at M0 and returns there after serving M1
    contention(2'b01, 2'b10);
    contention(2'b01, 2'b10);

    // Single request (leaves rr pointing at M1)
    ready_s0 = 1'b1;
    fork
      send(0, 0, 8'h25);
      begin
        @(negedge clk); chk("single_c0", gnt_s0, 2'b00);
        @(negedge clk);
        chk("single_gnt", gnt_s0, 2'b01);
        chk("single_vld", valid_s0, 1);
        chk("single_data", data_s0, 8'h25);
        chk("single_rdy", ready_m0, 1);
        @(negedge clk);
        chk("single_idle_gnt", gnt_s0, 2'b00);
        chk("single_idle_vld", valid_s0, 0);
        chk("single_hold", data_s0, 8'h25);
      end
    join
    tick();

    contention(2'b10, 2'b01);

    // Parallel grants to different slaves
    ready_s0 = 1'b1; ready_s1 = 1'b1;
    fork
      send(0, 1, 8'h30);
      send(1, 0, 8'h2F);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("par_gnt", {gnt_s1, gnt_s0}, 4'b0110);
        chk("par_vld", {valid_s1, valid_s0}, 2'b11);
        chk("par_rdy", {ready_m1, ready_m0}, 2'b11);
      end
    join
    tick();

    // Backpressure on slave 1
    ready_s1 = 1'b0;
    fork
      send(1, 1, 8'h3C);
      begin
        for (int k = 0; k <= 5; k++) begin
          @(negedge clk);
          if (k == 0) chk("bp_c0", gnt_s1, 2'b00);
          else begin
            chk($sformatf("bp_vld%0d", k), valid_s1, 1);
            chk($sformatf("bp_data%0d", k), data_s1, 8'h3C);
          end
          chk($sformatf("bp_rdy%0d", k), ready_m1, (k == 5));
          if (k == 4) begin @(posedge clk); #1; ready_s1 = 1'b1; end
        end
      end
    join
    tick();

    // Decode error
    fork
      send(0, 2, 8'h7F);
      begin
        @(negedge clk);
        chk("de_c0", {decerr_m0, ready_m0}, 2'b00);
        @(negedge clk);
        chk("de_pulse", {decerr_m0, ready_m0}, 2'b11);
        chk("de_noslv", {valid_s1, valid_s0}, 0);
        @(negedge clk);
        chk("de_after", {decerr_m0, ready_m0}, 2'b00);
      end
    join
    tick();

    // Reset in the middle of an M1 grant on slave 0
    ready_s0 = 1'b0;
    data_m1 = 8'h2B; valid_m1 = 1'b1;
    tick();
    @(negedge clk);
    chk("mr_gnt", gnt_s0, 2'b10);
    chk("mr_vld", valid_s0, 1);
    @(posedge clk); #1;
    rst = 1'b0; ready_s0 = 1'b1;
    tick();
    @(negedge clk);
    chk("mr_gnt_after", gnt_s0, 2'b00);
    chk("mr_vld_after", valid_s0, 0);
    valid_m1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Randomized traffic
    rand_rdy = 1'b1;
    fork
      master_run(0, 40);
      master_run(1, 40);
    join
    rand_rdy = 1'b0;
    repeat (3) tick();

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    chk("slave_hs_count", s_hs, m_hs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/handshake_xbar_arbiter.md
HANDSHAKE_XBAR_ARBITER -- requirements
Module: handshake_xbar_arbiter

Interface
REQ-001 The block SHALL have the parameter DW, default 8, the data and address-tag width.
REQ-002 The block SHALL have the parameter S0_TAG, default 4'h2, the value of data[7:4] that selects slave 0.
REQ-003 The block SHALL have the parameter S1_TAG, default 4'h3, the value of data[7:4] that selects slave 1.
REQ-004 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- data_m0, data_m1  in  DW  master payload; bits [7:4] are the destination tag.
- valid_m0, valid_m1  in  1  master valid.
- ready_m0, ready_m1  out  1  master ready.
- data_s0, data_s1  out  DW  slave payload.
- valid_s0, valid_s1  out  1  slave valid.
- ready_s0, ready_s1  in  1  slave ready.
- gnt_s0, gnt_s1  out  2  one-hot owner of each slave: bit0 = M0, bit1 = M1, 00 = idle.
- decerr_m0, decerr_m1  out  1  one-cycle pulse on a dropped, undecodable beat.

Function
REQ-005 The decode SHALL be: tag == S0_TAG requests slave 0; tag == S1_TAG requests slave 1; any other tag with valid high is a decode error.
REQ-006 Each slave SHALL have its own arbiter FSM with the states IDLE, OWN_M0 and OWN_M1.
REQ-007 Each slave SHALL have its own 1-bit round-robin pointer, rr, where 0 means M0 is preferred.
REQ-008 IDLE with exactly one requester SHALL go to that requester's OWN state at the next edge.
REQ-009 IDLE with both masters requesting the same slave SHALL grant the master indicated by rr.
REQ-010 IDLE with no requester SHALL remain IDLE.
REQ-011 Grant latency SHALL be one cycle: a request sampled at edge N gives ownership from cycle N+1.
REQ-012 While in OWN_Mx, the block SHALL drive data_sy = data_mx, valid_sy = valid_mx and ready_mx = ready_sy combinationally.
REQ-013 While in OWN_Mx, the non-owner's ready SHALL be 0 for that slave.
REQ-014 An OWN_Mx state SHALL end at the edge where valid_sy && ready_sy; the next state is IDLE and rr points at the other master.
REQ-015 Each grant SHALL cover exactly one beat.
REQ-016 The minimum beat spacing per slave SHALL be 2 cycles (grant cycle plus one idle cycle).
REQ-017 When the two masters target different slaves, both grants SHALL proceed concurrently and independently.
REQ-018 When a slave is IDLE, data_sy SHALL hold its last value and valid_sy SHALL be 0.
REQ-019 The gnt_sy output SHALL be registered and equal the FSM state (00, 01 or 10).
REQ-020 On a decode error, the block SHALL assert ready_mx for exactly one cycle, the cycle after valid is sampled.
REQ-021 On a decode error, the block SHALL pulse decerr_mx in that same cycle and discard the beat.
REQ-022 The decode-error sink SHALL re-arm only after valid_mx has been sampled in a following cycle.
REQ-023 A master SHALL hold data and valid stable until its handshake; the block is not required to tolerate a master's tag changing under valid.
REQ-024 If a master is stalled by one slave, its request SHALL NOT be taken by the other slave.
REQ-025 ready_mx SHALL be the OR of the per-slave ready terms; by construction, at most one term is active.

Reset
REQ-026 While rst == 0 at a clock edge, both FSMs SHALL go to IDLE and both rr pointers SHALL be set to 0.
REQ-027 While rst == 0 at a clock edge, gnt_s0 and gnt_s1 SHALL be set to 00.
REQ-028 While rst == 0 at a clock edge, decerr_m0/m1, valid_s0/s1 and ready_m0/m1 SHALL be 0 and data_s0/s1 SHALL be 0.
REQ-029 Reset asserted mid-ownership SHALL abort the grant with no handshake completed, and the beat is not delivered.
REQ-030 After reset is released, the first grant SHALL occur no earlier than one cycle after rst rises.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (IDLE = 2'b00, OWN_M0 = 2'b01, OWN_M1 = 2'b10), the default tags and the tag slice positions.
REQ-032 The per-slave FSM plus rr pointer SHALL be the sub-module rr_arb2, instantiated twice (slave 0, slave 1).
REQ-033 Decode, the decode-error sink and output muxing SHALL reside in the top module.

Verification
REQ-034 Reset: hold rst = 0 for 3 cycles with all valids high -> all outputs 0, gnt_s0 = gnt_s1 = 00.
REQ-035 Single request: M0 sends 8'h25 with ready_s0 = 1 -> gnt_s0 = 01 the next cycle, data_s0 = 8'h25 and valid_s0 = 1 for one cycle, ready_m0 = 1 that cycle.
REQ-036 Contention: M0 sends 8'h21 and M1 sends 8'h2A together, held, with ready_s0 = 1 -> M0 is served first, then after one idle cycle M1 (gnt_s0 sequence 01, 00, 10); a repeat after that grants M0 first only if rr has returned to 0.
REQ-037 Parallel: M0 sends 8'h30 and M1 sends 8'h2F -> gnt_s1 = 01 and gnt_s0 = 10 in the same cycle; both beats complete in that cycle.
REQ-038 Backpressure: M1 sends 8'h3C with ready_s1 = 0 for 4 cycles, then 1 -> valid_s1 = 1 is held for 5 cycles with data stable, and the handshake occurs in the 5th cycle.
REQ-039 Decode error and mid-grant reset: M0 sends 8'h7F -> ready_m0 and decerr_m0 pulse once, with no slave valid; separately, rst = 0 while gnt_s0 = 10 -> gnt_s0 = 00 and valid_s0 = 0 the next cycle.
